// File: rtl/poker_round_fsm.sv
// poker_round_fsm: sequences a poker game through hands, dealing phases and
// betting rounds, tracking the seat to act, the unfolded seats, the round and
// the hand number.
// Optional feature macro: POKER_RESTART_EN -- when defined, start_game in HALT
// restarts the game; when undefined, HALT is left only by reset.
module poker_round_fsm #(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_HANDS   = 32,
    parameter int NUM_ROUNDS  = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start_game,
    output logic                                               deal_req,
    input  logic                                               deal_ack,
    input  logic                                               act_valid,
    input  logic                                               act_fold,
    output logic [$clog2(NUM_PLAYERS)-1:0]                     cur_player,
    output logic [NUM_PLAYERS-1:0]                             active_mask,
    output logic [1:0]                                         round_idx,
    output logic [((NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1)-1:0] hand_number,
    output logic                                               showdown,
    output logic                                               hand_done,
    output logic [2:0]                                         game_state,
    output logic                                               game_over
);

    localparam int PW = $clog2(NUM_PLAYERS);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int CW = $clog2(NUM_PLAYERS + 1);

    localparam logic [NUM_PLAYERS-1:0] SEAT0      = NUM_PLAYERS'(1);
    localparam logic [PW-1:0]          LAST_SEAT  = PW'(NUM_PLAYERS - 1);
    localparam logic [HW-1:0]          LAST_HAND  = HW'(NUM_HANDS - 1);
    localparam logic [1:0]             LAST_ROUND = 2'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEAL     = 3'd1,
        S_BET      = 3'd2,
        S_SHOWDOWN = 3'd3,
        S_HAND_END = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t                 state_q,   state_d;
    logic [PW-1:0]          cur_q,     cur_d;
    logic [NUM_PLAYERS-1:0] mask_q,    mask_d;
    logic [1:0]             round_q,   round_d;
    logic [HW-1:0]          hand_q,    hand_d;
    logic [PW-1:0]          dealer_q,  dealer_d;
    logic [CW-1:0]          pending_q, pending_d;

    logic [NUM_PLAYERS-1:0] fold_mask;
    logic [CW-1:0]          remaining;

    // First unfolded seat at or after 'start', searching upward with wrap.
    function automatic logic [PW-1:0] first_at_or_after(
        input logic [NUM_PLAYERS-1:0] mask,
        input logic [PW-1:0]          start
    );
        logic [PW-1:0]          result;
        logic                   found;
        logic [NUM_PLAYERS-1:0] rot;
        int                     idx;
        result = start;
        found  = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            idx = (int'(start) + i) % NUM_PLAYERS;
            rot = mask >> idx;
            if (!found && rot[0]) begin
                result = PW'(idx);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // Next unfolded seat strictly after 'cur', with wrap.
    function automatic logic [PW-1:0] next_after(
        input logic [NUM_PLAYERS-1:0] mask,
        input logic [PW-1:0]          cur
    );
        logic [PW-1:0] start;
        start = (cur == LAST_SEAT) ? '0 : cur + 1'b1;
        return first_at_or_after(mask, start);
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [NUM_PLAYERS-1:0] mask);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            n = n + CW'(mask[i]);
        end
        return n;
    endfunction

    // Next-state and next-value logic for the game sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d   = state_q;
        cur_d     = cur_q;
        mask_d    = mask_q;
        round_d   = round_q;
        hand_d    = hand_q;
        dealer_d  = dealer_q;
        pending_d = pending_q;
        fold_mask = mask_q;
        remaining = '0;

        case (state_q)
            S_IDLE: begin
                if (start_game) begin
                    state_d  = S_DEAL;
                    hand_d   = '0;
                    round_d  = '0;
                    dealer_d = '0;
                    mask_d   = '1;
                end
            end

            S_DEAL: begin
                if (deal_ack) begin
                    state_d   = S_BET;
                    cur_d     = first_at_or_after(mask_q, dealer_q);
                    pending_d = popcount(mask_q);
                end
            end

            S_BET: begin
                if (act_valid) begin
                    fold_mask = act_fold ? (mask_q & ~(SEAT0 << cur_q)) : mask_q;
                    remaining = popcount(fold_mask);
                    mask_d    = fold_mask;
                    pending_d = pending_q - 1'b1;
                    cur_d     = next_after(fold_mask, cur_q);
                    // A fold-out ends the hand even if the round was also complete.
                    if (act_fold && remaining == CW'(1)) begin
                        state_d = S_HAND_END;
                    end else if (pending_q == CW'(1)) begin
                        if (round_q == LAST_ROUND) begin
                            state_d = S_SHOWDOWN;
                        end else begin
                            round_d = round_q + 1'b1;
                            state_d = S_DEAL;
                        end
                    end
                end
            end

            S_SHOWDOWN: begin
                state_d = S_HAND_END;
            end

            S_HAND_END: begin
                if (hand_q == LAST_HAND) begin
                    state_d = S_HALT;
                end else begin
                    hand_d   = hand_q + 1'b1;
                    dealer_d = (dealer_q == LAST_SEAT) ? '0 : dealer_q + 1'b1;
                    mask_d   = '1;
                    round_d  = '0;
                    state_d  = S_DEAL;
                end
            end

            S_HALT: begin
`ifdef POKER_RESTART_EN
                if (start_game) begin
                    state_d  = S_DEAL;
                    hand_d   = '0;
                    round_d  = '0;
                    dealer_d = '0;
                    mask_d   = '1;
                end
`else
                state_d = S_HALT;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            mask_q    <= '0;
            round_q   <= '0;
            hand_q    <= '0;
            dealer_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            round_q   <= round_d;
            hand_q    <= hand_d;
            dealer_q  <= dealer_d;
            pending_q <= pending_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    assign deal_req    = (state_q == S_DEAL);
    assign showdown    = (state_q == S_SHOWDOWN);
    assign hand_done   = (state_q == S_HAND_END);
    assign game_over   = (state_q == S_HALT);
    assign game_state  = state_q;
    assign cur_player  = cur_q;
    assign active_mask = mask_q;
    assign round_idx   = round_q;
    assign hand_number = hand_q;

endmodule

// File: tb/tb_poker_round_fsm.sv
// tb_poker_round_fsm: scoreboard bench for poker_round_fsm (4 seats, 2 hands,
// 4 rounds). Stimulus pushes the expected observable tuple for every state or
// seat change; a monitor pops and compares whenever that tuple changes.
module tb_poker_round_fsm;

    localparam int NP = 4;
    localparam int NH = 2;
    localparam int NR = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEAL = 3'd1;
    localparam logic [2:0] ST_BET  = 3'd2;
    localparam logic [2:0] ST_SHOW = 3'd3;
    localparam logic [2:0] ST_HEND = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    logic       clk;
    logic       reset;
    logic       start_game;
    logic       deal_req;
    logic       deal_ack;
    logic       act_valid;
    logic       act_fold;
    logic [1:0] cur_player;
    logic [3:0] active_mask;
    logic [1:0] round_idx;
    logic [0:0] hand_number;
    logic       showdown;
    logic       hand_done;
    logic [2:0] game_state;
    logic       game_over;

    poker_round_fsm #(
        .NUM_PLAYERS (NP),
        .NUM_HANDS   (NH),
        .NUM_ROUNDS  (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_game  (start_game),
        .deal_req    (deal_req),
        .deal_ack    (deal_ack),
        .act_valid   (act_valid),
        .act_fold    (act_fold),
        .cur_player  (cur_player),
        .active_mask (active_mask),
        .round_idx   (round_idx),
        .hand_number (hand_number),
        .showdown    (showdown),
        .hand_done   (hand_done),
        .game_state  (game_state),
        .game_over   (game_over)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] cur;
        logic [3:0] mask;
        logic [1:0] rnd;
        logic [0:0] hand;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sd_count = 0;
    int   sd_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [1:0] cur, input logic [3:0] mask,
                        input logic [1:0] rnd, input logic [0:0] hand);
        obs_t e;
        e.st   = st;
        e.cur  = cur;
        e.mask = mask;
        e.rnd  = rnd;
        e.hand = hand;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        start_game = 1'b1;
        step();
        start_game = 1'b0;
    endtask

    task automatic ack();
        deal_ack = 1'b1;
        step();
        deal_ack = 1'b0;
    endtask

    task automatic act(input logic fold);
        act_valid = 1'b1;
        act_fold  = fold;
        step();
        act_valid = 1'b0;
        act_fold  = 1'b0;
    endtask

    // Asynchronous reset: outputs must be at reset values before any clock edge.
    task automatic apply_reset(input string tag);
        step();
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b1;
        #1;
        check({tag, "_state"},     game_state,  ST_IDLE);
        check({tag, "_deal_req"},  deal_req,    1'b0);
        check({tag, "_showdown"},  showdown,    1'b0);
        check({tag, "_hand_done"}, hand_done,   1'b0);
        check({tag, "_game_over"}, game_over,   1'b0);
        check({tag, "_cur"},       cur_player,  2'd0);
        check({tag, "_mask"},      active_mask, 4'h0);
        check({tag, "_round"},     round_idx,   2'd0);
        check({tag, "_hand"},      hand_number, 1'b0);
        step();
        reset = 1'b0;
        step();
    endtask

    // Showdown pulse counter.
    always @(negedge clk) begin
        if (!reset && showdown) sd_count <= sd_count + 1;
    end

    // Monitor: every change of the observable tuple consumes one expectation.
    initial begin
        obs_t prev;
        obs_t now;
        obs_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            now.st   = game_state;
            now.cur  = cur_player;
            now.mask = active_mask;
            now.rnd  = round_idx;
            now.hand = hand_number;
            if (reset) begin
                prev = now;
            end else if (now != prev) begin
                prev = now;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got state %0d cur %0d mask %b round %0d hand %0d, expected no event",
                             now.st, now.cur, now.mask, now.rnd, now.hand);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_state",     now.st,    e.st);
                    check("ev_cur",       now.cur,   e.cur);
                    check("ev_mask",      now.mask,  e.mask);
                    check("ev_round",     now.rnd,   e.rnd);
                    check("ev_hand",      now.hand,  e.hand);
                    check("ev_deal_req",  deal_req,  e.st == ST_DEAL);
                    check("ev_showdown",  showdown,  e.st == ST_SHOW);
                    check("ev_hand_done", hand_done, e.st == ST_HEND);
                    check("ev_game_over", game_over, e.st == ST_HALT);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start_game = 1'b0;
        deal_ack   = 1'b0;
        act_valid  = 1'b0;
        act_fold   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",     game_state,  ST_IDLE);
        check("rst_deal_req",  deal_req,    1'b0);
        check("rst_game_over", game_over,   1'b0);
        check("rst_mask",      active_mask, 4'h0);
        reset = 1'b0;
        step();
        step();
        check("idle_hold", game_state, ST_IDLE);

        // ---- Game 1, hand 0: four full rounds, no folds ----
        push(ST_DEAL, 2'd0, 4'hF, 2'd0, 1'b0);
        start();
        step();
        check("deal_req_held", deal_req, 1'b1);
        sd_base = sd_count;
        for (int r = 0; r < NR; r++) begin
            push(ST_BET, 2'd0, 4'hF, 2'(r), 1'b0);
            ack();
            check("bet_entry_deal_req", deal_req, 1'b0);
            for (int s = 0; s < NP; s++) begin
                if (s < NP - 1)  push(ST_BET,  2'(s + 1), 4'hF, 2'(r),     1'b0);
                else if (r < 3)  push(ST_DEAL, 2'd0,      4'hF, 2'(r + 1), 1'b0);
                else             push(ST_SHOW, 2'd0,      4'hF, 2'd3,      1'b0);
                act(1'b0);
            end
        end
        check("showdown_pulse", showdown, 1'b1);
        push(ST_HEND, 2'd0, 4'hF, 2'd3, 1'b0);
        push(ST_DEAL, 2'd0, 4'hF, 2'd0, 1'b1);
        step();
        check("hand_done_after_showdown", hand_done, 1'b1);
        step();
        check("hand_number_next", hand_number, 1'b1);
        check("showdown_count_full_hand", sd_count - sd_base, 1);

        // ---- Game 1, hand 1: dealer 1, seats 1,2,0 fold -> HALT ----
        push(ST_BET, 2'd1, 4'hF, 2'd0, 1'b1);
        ack();
        check("hand1_first_seat", cur_player, 2'd1);
        push(ST_BET, 2'd2, 4'hD, 2'd0, 1'b1);
        act(1'b1);
        push(ST_BET, 2'd3, 4'h9, 2'd0, 1'b1);
        act(1'b1);
        push(ST_BET, 2'd0, 4'h9, 2'd0, 1'b1);
        act(1'b0);
        push(ST_HEND, 2'd3, 4'h8, 2'd0, 1'b1);
        push(ST_HALT, 2'd3, 4'h8, 2'd0, 1'b1);
        act(1'b1);
        check("foldout_hand_end", game_state, ST_HEND);
        step();
        check("halt_state", game_state, ST_HALT);
        check("halt_game_over", game_over, 1'b1);
`ifdef POKER_RESTART_EN
        push(ST_DEAL, 2'd3, 4'hF, 2'd0, 1'b0);
        start();
        check("restart_state", game_state, ST_DEAL);
        check("restart_hand", hand_number, 1'b0);
`else
        start();
        step();
        check("halt_sticky_state", game_state, ST_HALT);
        check("halt_sticky_game_over", game_over, 1'b1);
`endif
        apply_reset("rst_after_game");

        // ---- Game 2: stray inputs, fold skip and wrap, mid-DEAL reset ----
        push(ST_DEAL, 2'd0, 4'hF, 2'd0, 1'b0);
        start();
        act_valid = 1'b1;
        act_fold  = 1'b1;
        step();
        act_valid = 1'b0;
        act_fold  = 1'b0;
        check("stray_act_state", game_state, ST_DEAL);
        check("stray_act_mask", active_mask, 4'hF);
        push(ST_BET, 2'd0, 4'hF, 2'd0, 1'b0);
        ack();
        deal_ack = 1'b1;
        step();
        deal_ack = 1'b0;
        act_fold = 1'b1;
        step();
        act_fold = 1'b0;
        check("stray_ack_state", game_state, ST_BET);
        check("stray_ack_cur", cur_player, 2'd0);
        check("stray_fold_mask", active_mask, 4'hF);
        push(ST_BET,  2'd1, 4'hF, 2'd0, 1'b0);
        act(1'b0);
        push(ST_BET,  2'd2, 4'hF, 2'd0, 1'b0);
        act(1'b0);
        push(ST_BET,  2'd3, 4'hB, 2'd0, 1'b0);
        act(1'b1);
        push(ST_DEAL, 2'd0, 4'hB, 2'd1, 1'b0);
        act(1'b0);
        check("pending_intact_round1", round_idx, 2'd1);
        push(ST_BET,  2'd0, 4'hB, 2'd1, 1'b0);
        ack();
        push(ST_BET,  2'd1, 4'hB, 2'd1, 1'b0);
        act(1'b0);
        push(ST_BET,  2'd3, 4'hB, 2'd1, 1'b0);
        act(1'b0);
        check("skip_folded_seat", cur_player, 2'd3);
        push(ST_DEAL, 2'd0, 4'hB, 2'd2, 1'b0);
        act(1'b0);
        check("round2_deal", game_state, ST_DEAL);
        push(ST_BET,  2'd0, 4'hB, 2'd2, 1'b0);
        ack();
        push(ST_BET,  2'd1, 4'hA, 2'd2, 1'b0);
        act(1'b1);
        push(ST_HEND, 2'd3, 4'h8, 2'd2, 1'b0);
        push(ST_DEAL, 2'd3, 4'hF, 2'd0, 1'b1);
        act(1'b1);
        step();
        check("mid_deal_req", deal_req, 1'b1);
        apply_reset("rst_mid_deal");

        // ---- Game 3: seats 0,1,2 fold in round 0 ----
        push(ST_DEAL, 2'd0, 4'hF, 2'd0, 1'b0);
        start();
        sd_base = sd_count;
        push(ST_BET,  2'd0, 4'hF, 2'd0, 1'b0);
        ack();
        push(ST_BET,  2'd1, 4'hE, 2'd0, 1'b0);
        act(1'b1);
        push(ST_BET,  2'd2, 4'hC, 2'd0, 1'b0);
        act(1'b1);
        push(ST_HEND, 2'd3, 4'h8, 2'd0, 1'b0);
        push(ST_DEAL, 2'd3, 4'hF, 2'd0, 1'b1);
        act(1'b1);
        check("foldout3_state", game_state, ST_HEND);
        check("foldout3_mask", active_mask, 4'h8);
        step();
        check("foldout3_next_deal", game_state, ST_DEAL);
        step();
        step();
        check("foldout3_no_showdown", sd_count - sd_base, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
